// File: rtl/rmw_pkg.sv
// -----------------------------------------------------------------------------
// rmw_pkg
//
// Purpose:
//   Shared definitions for the read-modify-write sequencer that drives the
//   write side of the 16x16 register file.
//
// Contents:
//   RMW_ADDR_W   - default register-file address width
//   RMW_DATA_W   - default register-file data width
//   rmw_state_t  - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package rmw_pkg;

    // Geometry of the register file that this engine sits in front of.
    localparam int unsigned RMW_ADDR_W = 4;
    localparam int unsigned RMW_DATA_W = 16;

    // One RMW walks IDLE -> READ -> WRITE -> ADVANCE -> IDLE. The encoding is
    // fixed so that the state is easy to recognise on a bring-up probe.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        ADVANCE = 2'd3
    } rmw_state_t;

endpackage : rmw_pkg

// File: rtl/rmw_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Purpose:
//   Rate divider for the RMW engine. Counts 0..TICK_DIV-1 while enabled and
//   raises tick for the single cycle in which the count sits at TICK_DIV-1.
//   While disabled the count is frozen, so pausing and resuming does not
//   restart the period.
//
// Parameters:
//   TICK_DIV - clk cycles between ticks (the sequencer needs >= 4)
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-low reset (count returns to 0)
//   en   in   1 = count, 0 = hold
//   tick out  one-cycle pulse at the end of each period while enabled
// -----------------------------------------------------------------------------
module tick_gen
    import rmw_pkg::*;
#(
    parameter int unsigned TICK_DIV = 781250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    // At least one bit of counter even for degenerate divisors.
    localparam int unsigned      CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);

    // NOTE: clocked state is written with <= so every flop samples the values
    // from before the edge; a blocking = here would let later statements in
    // the same block see the new value and silently change the logic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Gated with en so a count frozen at the last value while paused does not
    // present a stale tick.
    assign tick = en && w_at_last;

endmodule : tick_gen

// File: rtl/rmw_sequencer.sv
// -----------------------------------------------------------------------------
// rmw_sequencer
//
// Purpose:
//   Periodic read-modify-write engine in front of the register file. On each
//   rate tick (run=1) or on a step request (run=0) it reads the entry at the
//   current address through the file's combinational read port, adds STEP,
//   writes the sum back and moves on to the next address, wrapping after the
//   last entry.
//
// Parameters:
//   TICK_DIV - clk cycles between automatic RMW operations (>= 4)
//   ADDR_W   - register-file address width
//   DATA_W   - register-file data width
//   STEP     - value added to each entry per RMW
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-low reset
//   run         in   1 = free-running on ticks, 0 = paused / step mode
//   step_req    in   one-cycle pulse: one RMW when run=0 and idle
//   rd_data     in   register-file read data for rd_addr (same cycle)
//   rd_addr     out  register-file read address (always the current address)
//   wr_en       out  register-file write enable
//   wr_addr     out  register-file write address
//   wr_data     out  register-file write data
//   busy        out  high whenever an RMW is in flight
//   wrap_pulse  out  one-cycle pulse as the address rolls from max to 0
//
// Timing of one RMW (trigger sampled in IDLE at cycle t):
//   t+1 READ (capture rd_data + STEP), t+2 WRITE (wr_en), t+3 ADVANCE,
//   t+4 back in IDLE. All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module rmw_sequencer
    import rmw_pkg::*;
#(
    parameter int unsigned       TICK_DIV = 781250,
    parameter int unsigned       ADDR_W   = RMW_ADDR_W,
    parameter int unsigned       DATA_W   = RMW_DATA_W,
    parameter logic [DATA_W-1:0] STEP     = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step_req,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              wrap_pulse
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    // -------------------------------------------------------------------------
    // Rate tick: only advances while run=1.
    // -------------------------------------------------------------------------
    logic w_tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .tick (w_tick)
    );

    // -------------------------------------------------------------------------
    // FSM and datapath registers
    // -------------------------------------------------------------------------
    rmw_state_t        r_state;
    rmw_state_t        w_next_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [DATA_W-1:0] r_data_q;
    logic              w_trigger;

    // Automatic and manual triggers are mutually exclusive through run, so a
    // tick coinciding with a step request still launches a single RMW. The
    // trigger is only consulted in IDLE, which drops anything arriving while
    // an operation is in flight.
    assign w_trigger = (run && w_tick) || (!run && step_req);

    // NOTE: every output of a combinational block gets a default before the
    // case; a path that leaves it unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_next_state = READ;
                end
            end
            READ:    w_next_state = WRITE;
            WRITE:   w_next_state = ADVANCE;
            ADVANCE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A reset landing mid-operation returns straight to IDLE, so a write that
    // was about to be issued is simply never presented.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cur_addr <= '0;
            r_data_q   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                // Sum wraps modulo 2^DATA_W (all-ones + 1 becomes 0).
                READ:    r_data_q   <= rd_data + STEP;
                ADVANCE: r_cur_addr <= r_cur_addr + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs
    // -------------------------------------------------------------------------
    assign rd_addr = r_cur_addr;
    assign busy    = (r_state != IDLE);
    assign wr_en   = (r_state == WRITE);

    // Write address/data are held at zero outside the write cycle so the bus
    // is quiet whenever wr_en is low.
    assign wr_addr = wr_en ? r_cur_addr : '0;
    assign wr_data = wr_en ? r_data_q   : '0;

    // ADVANCE still shows the pre-increment address, so max here means the
    // increment about to happen rolls over to 0.
    assign wrap_pulse = (r_state == ADVANCE) && (r_cur_addr == ADDR_MAX);

endmodule : rmw_sequencer

// File: tb/tb_rmw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rmw_sequencer
//
// Drives rmw_sequencer against a behavioural register file. A reference model
// at the trigger level predicts every write (cycle, address, data) and every
// wrap pulse into scoreboard queues; a monitor on the falling edge pops and
// compares whenever the DUT shows wr_en or wrap_pulse, and also tracks busy
// and rd_addr every cycle.
// -----------------------------------------------------------------------------
module tb_rmw_sequencer;

    localparam int unsigned       TICK_DIV = 4;
    localparam int unsigned       ADDR_W   = 4;
    localparam int unsigned       DATA_W   = 16;
    localparam int                DEPTH    = 16;
    localparam logic [DATA_W-1:0] STEP     = 16'd1;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              step_req;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              wrap_pulse;

    always #5 clk = ~clk;

    rmw_sequencer #(
        .TICK_DIV (TICK_DIV),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .STEP     (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step_req   (step_req),
        .rd_data    (rd_data),
        .rd_addr    (rd_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .wrap_pulse (wrap_pulse)
    );

    // Behavioural register file: async read, write on rising edge.
    logic [DATA_W-1:0] regfile [DEPTH];
    assign rd_data = regfile[rd_addr];
    always @(posedge clk) begin
        if (wr_en === 1'b1) regfile[wr_addr] <= wr_data;
    end

    // -------------------------------------------------------------------------
    // Checking infrastructure
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model. cyc numbers the clock periods; at each rising edge the
    // model consumes the inputs of the period that just ended. Rules:
    //   - a tick occurs in a run=1 period whose count of earlier run=1 periods
    //     (since reset) is TICK_DIV-1 modulo TICK_DIV;
    //   - a trigger in period c while idle: busy c+1..c+3, write in c+2 of
    //     (entry + STEP) mod 2^16, address advances after c+3, wrap in c+3 if
    //     the address was the last one;
    //   - reset discards anything not yet written.
    // -------------------------------------------------------------------------
    typedef struct {
        int cyc;
        int addr;
        int data;
        int old;
    } exp_wr_t;

    exp_wr_t exp_wr[$];
    int      exp_wrap[$];
    int      model_mem [DEPTH];
    int      cyc     = 0;
    int      run_cnt = 0;
    int      trig_c  = -1;
    int      m_addr  = 0;

    always @(posedge clk) begin : model
        exp_wr_t e;
        int      c;
        bit      idle;
        bit      tick_now;
        c = cyc;
        if (rst !== 1'b1) begin
            while (exp_wr.size() > 0) begin
                e = exp_wr.pop_back();
                model_mem[e.addr] = e.old;
            end
            exp_wrap.delete();
            run_cnt = 0;
            trig_c  = -1;
            m_addr  = 0;
        end else begin
            idle     = (trig_c < 0) || (c >= trig_c + 4);
            tick_now = (run === 1'b1) &&
                       ((run_cnt % int'(TICK_DIV)) == int'(TICK_DIV) - 1);
            if (run === 1'b1) run_cnt++;
            if (trig_c >= 0 && c == trig_c + 3) m_addr = (m_addr + 1) % DEPTH;
            if (idle && (tick_now || (run === 1'b0 && step_req === 1'b1))) begin
                e.cyc  = c + 2;
                e.addr = m_addr;
                e.old  = model_mem[m_addr];
                e.data = (e.old + int'(STEP)) % 65536;
                model_mem[m_addr] = e.data;
                exp_wr.push_back(e);
                if (m_addr == DEPTH - 1) exp_wrap.push_back(c + 3);
                trig_c = c;
            end
        end
        cyc++;
    end

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    bit mon_en     = 1'b0;
    int wr_count   = 0;
    int wrap_count = 0;

    always @(negedge clk) begin : monitor
        exp_wr_t e;
        bit      exp_busy;
        if (mon_en) begin
            exp_busy = (trig_c >= 0) && (cyc > trig_c) && (cyc <= trig_c + 3);
            check("busy", 32'(busy), 32'(exp_busy));
            check("rd_addr", 32'(rd_addr), m_addr);

            if (wr_en === 1'b1) begin
                wr_count++;
                if (exp_wr.size() == 0) begin
                    check("wr_en_unexpected", 32'(wr_en), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr", 32'(wr_addr), e.addr);
                    check("wr_data", 32'(wr_data), e.data);
                end
            end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
                check("wr_en_missing", 32'(wr_en), 32'd1);
                void'(exp_wr.pop_front());
            end

            if (wrap_pulse === 1'b1) begin
                wrap_count++;
                if (exp_wrap.size() == 0) begin
                    check("wrap_unexpected", 32'(wrap_pulse), 32'd0);
                end else begin
                    check("wrap_cycle", cyc, exp_wrap.pop_front());
                end
            end else if (exp_wrap.size() > 0 && exp_wrap[0] <= cyc) begin
                check("wrap_missing", 32'(wrap_pulse), 32'd1);
                void'(exp_wrap.pop_front());
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    initial begin : stim
        int          base;
        int          hold;
        int unsigned v;

        rst      = 1'b0;
        run      = 1'b0;
        step_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            regfile[i]   = '0;
            model_mem[i] = 0;
        end

        // 1: two reset edges, then quiet for 20 cycles with run=0.
        next_cycle();
        mon_en = 1'b1;
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t1_wr_en", 32'(wr_en), 32'd0);
            check("t1_wr_addr", 32'(wr_addr), 32'd0);
            check("t1_wr_data", 32'(wr_data), 32'd0);
            check("t1_rd_addr", 32'(rd_addr), 32'd0);
            check("t1_busy", 32'(busy), 32'd0);
            check("t1_wrap", 32'(wrap_pulse), 32'd0);
        end
        next_cycle();

        // 2/3: free-run for 72 cycles (18 ticks) from a zero count.
        base = wr_count;
        run  = 1'b1;
        idle_cycles(5);
        @(negedge clk);
        check("t2_first_wr_en", 32'(wr_en), 32'd1);
        check("t2_first_wr_addr", 32'(wr_addr), 32'd0);
        check("t2_first_wr_data", 32'(wr_data), 32'h0001);
        idle_cycles(4);
        @(negedge clk);
        check("t2_second_wr_en", 32'(wr_en), 32'd1);
        check("t2_second_wr_addr", 32'(wr_addr), 32'd1);
        idle_cycles(63);
        run = 1'b0;
        idle_cycles(8);
        check("t3_write_count", wr_count - base, 32'd18);
        check("t3_wrap_count", wrap_count, 32'd1);

        // 4: step mode with entry 0 at all-ones; second request while busy.
        reset_pulse();
        regfile[0]   = 16'hFFFF;
        model_mem[0] = 32'hFFFF;
        base     = wr_count;
        step_req = 1'b1;
        next_cycle();
        next_cycle();
        step_req = 1'b0;
        @(negedge clk);
        check("t4_wr_en", 32'(wr_en), 32'd1);
        check("t4_wr_addr", 32'(wr_addr), 32'd0);
        check("t4_wr_data", 32'(wr_data), 32'h0000);
        idle_cycles(6);
        check("t4_write_count", wr_count - base, 32'd1);

        // 5: reset during READ abandons the write; next write targets 0.
        base     = wr_count;
        step_req = 1'b1;
        next_cycle();
        step_req = 1'b0;
        rst      = 1'b0;
        next_cycle();
        rst = 1'b1;
        idle_cycles(6);
        @(negedge clk);
        check("t5_no_write", wr_count - base, 32'd0);
        check("t5_rd_addr", 32'(rd_addr), 32'd0);
        next_cycle();
        step_req = 1'b1;
        next_cycle();
        step_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("t5_wr_en", 32'(wr_en), 32'd1);
        check("t5_wr_addr", 32'(wr_addr), 32'd0);
        check("t5_wr_data", 32'(wr_data), 32'h0001);
        idle_cycles(6);

        // 6: run=1 with step_req held high: only ticks produce writes.
        reset_pulse();
        base     = wr_count;
        run      = 1'b1;
        step_req = 1'b1;
        idle_cycles(40);
        run      = 1'b0;
        step_req = 1'b0;
        idle_cycles(8);
        check("t6_write_count", wr_count - base, 32'd10);

        // Random phase: random contents, run periods, step pulses, resets.
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) begin
            v            = $urandom_range(0, 65535);
            regfile[i]   = v[15:0];
            model_mem[i] = int'(v);
        end
        regfile[5]   = 16'hFFFF;
        model_mem[5] = 32'hFFFF;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                run  = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 30));
            end
            hold--;
            step_req = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 199) != 0);
            next_cycle();
        end
        rst      = 1'b1;
        run      = 1'b0;
        step_req = 1'b0;
        idle_cycles(8);

        check("scoreboard_writes_drained", exp_wr.size(), 32'd0);
        check("scoreboard_wraps_drained", exp_wrap.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rmw_sequencer
